instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
Sequential MIPS instruction encoder and program loader. It accepts symbolic instructions (kind plus register/immediate fields) over a valid/ready handshake. It encodes each one into the 32-bit MIPS word that the control decoder consumes, and writes it into instruction memory at consecutive word addresses. It sits between the testbench/boot source and the instruction-memory write port, and runs before the core leaves reset.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width; capacity is 2**ADDR_WIDTH words.
BASE_ADDR, 0, word address of the first write. Must be less than 2**ADDR_WIDTH.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  an instruction is presented.
in_ready  output  1  the loader can accept an instruction this cycle.
in_kind  input  4  instruction kind: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 NOR, 6 ADDI, 7 LW, 8 SW, 9 BEQ, 10 BNE, 11 J, 12-15 illegal.
in_rs  input  5  rs field.
in_rt  input  5  rt field.
in_rd  input  5  rd field; used by R-type only.
in_imm  input  16  immediate or branch offset; used by I-type only.
in_target  input  26  jump target; used by J only.
in_last  input  1  this is the final instruction of the program.
imem_we  output  1  instruction-memory write strobe, one cycle per word.
imem_addr  output  ADDR_WIDTH  word address of the write.
imem_wdata  output  32  encoded instruction word.
count  output  ADDR_WIDTH+1  number of words written since reset.
done  output  1  loading has finished; sticky until reset.
error  output  1  an illegal kind was received; sticky until reset.

Behaviour:
- Reset (asynchronous, active-high): all outputs are 0 immediately. state=IDLE, write pointer=BASE_ADDR, count=0. A reset asserted mid-WRITE aborts the write; imem_we drops in the same cycle.
- FSM states: IDLE, WRITE, DONE.
- in_ready = 1 only in IDLE. A transfer occurs on a clk edge where in_valid && in_ready. Fields are sampled only at the transfer and may change freely afterwards.
- IDLE, on a legal transfer: register the encoded word and go to WRITE.
- WRITE lasts exactly one cycle:
  - imem_we=1, imem_addr=pointer, imem_wdata=registered word.
  - On exit: pointer+1, count+1.
  - Next state is DONE if in_last was set on that transfer, or if the pointer was 2**ADDR_WIDTH-1 (memory full, no wrap). Otherwise IDLE.
- Write latency: imem_we is high in the cycle immediately after the transfer edge. Peak throughput is one instruction per 2 cycles.
- Illegal kind (12-15): the transfer is still accepted, but no write occurs. error=1 from the next cycle. Pointer and count are unchanged. The FSM stays in IDLE, or goes to DONE if in_last was set.
- DONE: done=1, in_ready=0, imem_we=0. The FSM holds in DONE until rst. in_valid is ignored, and no wrap-around or overwrite ever occurs.
- Encoding, as fields from bit 31 down to bit 0:
  - R-type: 000000 | rs | rt | rd | 00000 | funct. Funct is ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010, NOR 100111.
  - I-type: op | rs | rt | imm. Op is ADDI 001000, LW 100011, SW 101011, BEQ 000100, BNE 000101. The immediate is passed through unmodified; it is not sign-processed.
  - J: 000010 | target.
  - Fields a kind does not use are ignored and are not reflected in the word.
- imem_addr and imem_wdata are registered. Their values outside WRITE are don't-care, but they must not be X after reset.

Test Plan:
- Single ADD: kind=0, rs=1, rt=2, rd=3, in_last=1 -> one imem_we pulse at addr 0 with data 0x00221820. done=1 the following cycle, count=1.
- Stream with in_valid held high: LW rs=9, rt=8, imm=4; then BEQ rs=1, rt=2, imm=0xFFFF; then J target=0x10 with in_last=1.
  - Writes: 0x8D280004 @0, 0x1022FFFF @1, 0x08000010 @2.
  - in_ready toggles 1,0 between transfers.
  - Final state: count=3, done=1.
- Illegal kind: kind=13, then ADDI rs=0, rt=5, imm=7 -> no write for kind 13; error=1 and stays 1. The ADDI writes 0x20050007 at addr 0, count=1.
- Full memory with ADDR_WIDTH=2, BASE_ADDR=0: 5 ADD instructions offered, none with in_last -> writes at addrs 0..3. done=1 after the 4th write, count=4. The 5th instruction is never accepted (in_ready=0).
- Reset mid-operation: assert rst during the WRITE cycle of the 2nd instruction -> imem_we=0 immediately, count=0. After release, the next write goes to BASE_ADDR.
- Ignored fields: SW rs=29, rt=31, imm=0x0010, with rd=31 and target=all ones -> 0xAFBF0010.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// Instruction handshake and instruction-memory write bus for the loader.
// The loader sits on the slave side; the boot source or bench drives the master side.
interface instr_encoder_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_kind;
  logic [4:0]            in_rs;
  logic [4:0]            in_rt;
  logic [4:0]            in_rd;
  logic [15:0]           in_imm;
  logic [25:0]           in_target;
  logic                  in_last;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic MIPS instructions and writes them to consecutive instruction-memory
// words; stops on the last instruction or when memory is full, never wrapping.
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_encoder_loader_if.slave bus,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  done,
  output logic                  error
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  last_q, last_d;
  logic                  error_q, error_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;

  logic                  transfer;
  logic                  kind_legal;
  logic [31:0]           enc_word;

  function automatic logic [31:0] encode(
    input logic [3:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    w = '0;
    case (kind)
      4'd0:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      4'd1:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      4'd2:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
      4'd3:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
      4'd4:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      4'd5:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100111};
      4'd6:    w = {6'b001000, rs, rt, imm};
      4'd7:    w = {6'b100011, rs, rt, imm};
      4'd8:    w = {6'b101011, rs, rt, imm};
      4'd9:    w = {6'b000100, rs, rt, imm};
      4'd10:   w = {6'b000101, rs, rt, imm};
      4'd11:   w = {6'b000010, target};
      default: w = '0;
    endcase
    return w;
  endfunction

  assign kind_legal = (bus.in_kind < 4'd12);
  assign transfer   = bus.in_valid && ready_q && (state_q == ST_IDLE);
  assign enc_word   = encode(bus.in_kind, bus.in_rs, bus.in_rt, bus.in_rd,
                             bus.in_imm, bus.in_target);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    error_d = error_q;

    case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          if (kind_legal) begin
            wdata_d = enc_word;
            addr_d  = ptr_q;
            last_d  = bus.in_last;
            state_d = ST_WRITE;
          end else begin
            error_d = 1'b1;
            state_d = bus.in_last ? ST_DONE : ST_IDLE;
          end
        end
      end
      ST_WRITE: begin
        // The pointer may wrap to zero here only when we stop anyway.
        ptr_d   = ptr_q + ADDR_WIDTH'(1);
        count_d = count_q + CW'(1);
        state_d = (last_q || (ptr_q == LAST_ADDR)) ? ST_DONE : ST_IDLE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
    we_d    = (state_d == ST_WRITE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= BASE;
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      error_q <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      error_q <= error_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign count          = count_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed cases plus randomized
// programs compared against a table-driven reference model of the loader.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        validA = 1'b0;
  logic        validB = 1'b0;
  logic [3:0]  kind = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic        last = 1'b0;

  logic [8:0]  countA;
  logic        doneA, errorA;
  logic [2:0]  countB;
  logic        doneB, errorB;

  int checks = 0;
  int failures = 0;

  logic [63:0] obsA[$];
  logic [63:0] obsB[$];
  logic [63:0] expQ[$];

  // Reference model state for whichever DUT is under test.
  int unsigned modelPtr;
  int unsigned modelCount;
  bit          modelErr;
  bit          modelDone;

  int unsigned opTab[12] = '{0, 0, 0, 0, 0, 0, 8, 35, 43, 4, 5, 2};
  int unsigned fnTab[6]  = '{32, 34, 36, 37, 42, 39};

  instr_encoder_loader_if #(.ADDR_WIDTH(8)) ifA ();
  instr_encoder_loader_if #(.ADDR_WIDTH(2)) ifB ();

  assign ifA.in_valid  = validA;
  assign ifA.in_kind   = kind;
  assign ifA.in_rs     = rs;
  assign ifA.in_rt     = rt;
  assign ifA.in_rd     = rd;
  assign ifA.in_imm    = imm;
  assign ifA.in_target = target;
  assign ifA.in_last   = last;

  assign ifB.in_valid  = validB;
  assign ifB.in_kind   = kind;
  assign ifB.in_rs     = rs;
  assign ifB.in_rt     = rt;
  assign ifB.in_rd     = rd;
  assign ifB.in_imm    = imm;
  assign ifB.in_target = target;
  assign ifB.in_last   = last;

  instr_encoder_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dutA (
    .clk(clk), .rst(rst), .bus(ifA.slave),
    .count(countA), .done(doneA), .error(errorA)
  );

  instr_encoder_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dutB (
    .clk(clk), .rst(rst), .bus(ifB.slave),
    .count(countB), .done(doneB), .error(errorB)
  );

  always #5 clk = ~clk;

  // Record every write strobe seen on either memory port, sampled mid-cycle.
  always @(negedge clk) begin
    if (ifA.imem_we === 1'b1) obsA.push_back({24'd0, ifA.imem_addr, ifA.imem_wdata});
    if (ifB.imem_we === 1'b1) obsB.push_back({30'd0, ifB.imem_addr, ifB.imem_wdata});
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] encodeModel(input int unsigned k, input int unsigned s,
                                              input int unsigned t, input int unsigned d,
                                              input int unsigned im, input int unsigned tg);
    int unsigned w;
    if (k <= 5)       w = s * (1 << 21) + t * (1 << 16) + d * (1 << 11) + fnTab[k];
    else if (k <= 10) w = opTab[k] * (1 << 26) + s * (1 << 21) + t * (1 << 16) + im;
    else              w = opTab[k] * (1 << 26) + tg;
    return w;
  endfunction

  function automatic void modelClear();
    modelPtr   = 0;
    modelCount = 0;
    modelErr   = 1'b0;
    modelDone  = 1'b0;
    expQ.delete();
  endfunction

  // Drive one instruction and wait (bounded) for it to be accepted.
  task automatic applyStimulus(input bit sel, input logic [3:0] k, input logic [4:0] s,
                               input logic [4:0] t, input logic [4:0] d,
                               input logic [15:0] im, input logic [25:0] tg,
                               input logic lst, input int budget,
                               output bit accepted, output int waits);
    logic rdy;
    @(negedge clk);
    kind = k; rs = s; rt = t; rd = d; imm = im; target = tg; last = lst;
    if (sel) validB = 1'b1; else validA = 1'b1;
    accepted = 1'b0;
    waits = 0;
    while (waits < budget) begin
      rdy = sel ? ifB.in_ready : ifA.in_ready;
      if (rdy === 1'b1) begin
        accepted = 1'b1;
        break;
      end
      waits++;
      @(negedge clk);
    end
    if (accepted) @(posedge clk);
    #1;
    validA = 1'b0;
    validB = 1'b0;
  endtask

  // Update the model for one offered instruction, then drive it and check acceptance.
  task automatic sendInstr(input bit sel, input int unsigned capacity, input logic [3:0] k,
                           input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                           input logic [15:0] im, input logic [25:0] tg, input logic lst,
                           output int waits);
    bit expAcc, acc;
    expAcc = !modelDone;
    if (expAcc) begin
      if (k < 12) begin
        expQ.push_back({modelPtr, encodeModel(k, s, t, d, im, tg)});
        modelPtr++;
        modelCount++;
        if (lst || modelPtr == capacity) modelDone = 1'b1;
      end else begin
        modelErr = 1'b1;
        if (lst) modelDone = 1'b1;
      end
    end
    applyStimulus(sel, k, s, t, d, im, tg, lst, expAcc ? 50 : 8, acc, waits);
    checkOutput("accepted", {63'd0, acc}, {63'd0, expAcc});
  endtask

  task automatic verifyRun(input bit sel, input string name);
    logic [63:0] obs[$];
    logic [63:0] cnt;
    logic dn, er, rdy;
    repeat (2) @(negedge clk);
    if (sel) obs = obsB; else obs = obsA;
    cnt = sel ? {61'd0, countB} : {55'd0, countA};
    dn  = sel ? doneB : doneA;
    er  = sel ? errorB : errorA;
    rdy = sel ? ifB.in_ready : ifA.in_ready;
    checkOutput({name, "_nwrites"}, 64'(obs.size()), 64'(expQ.size()));
    for (int i = 0; i < obs.size() && i < expQ.size(); i++)
      checkOutput($sformatf("%s_write%0d", name, i), obs[i], expQ[i]);
    checkOutput({name, "_count"}, cnt, 64'(modelCount));
    checkOutput({name, "_done"}, {63'd0, dn}, {63'd0, modelDone});
    checkOutput({name, "_error"}, {63'd0, er}, {63'd0, modelErr});
    checkOutput({name, "_ready"}, {63'd0, rdy}, {63'd0, !modelDone});
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_we", {62'd0, ifA.imem_we, ifB.imem_we}, 64'd0);
    checkOutput("rst_ready", {62'd0, ifA.in_ready, ifB.in_ready}, 64'd0);
    checkOutput("rst_done_err", {60'd0, doneA, errorA, doneB, errorB}, 64'd0);
    checkOutput("rst_count", {52'd0, countA, countB}, 64'd0);
    checkOutput("rst_addr_data", {22'd0, ifA.imem_addr, ifB.imem_addr, ifA.imem_wdata}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    obsA.delete();
    obsB.delete();
    modelClear();
  endtask

  initial begin
    int w;
    $display("[TB] starting instr_encoder_loader bench");

    // Single ADD with last.
    resetDut();
    sendInstr(0, 256, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, w);
    checkOutput("add_word", {32'd0, expQ[0][31:0]}, 64'h0000_0000_0022_1820);
    verifyRun(0, "single_add");

    // Back-to-back stream: LW, BEQ, J(last).
    resetDut();
    sendInstr(0, 256, 4'd7, 5'd9, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b0, w);
    sendInstr(0, 256, 4'd9, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 1'b0, w);
    checkOutput("stream_ready_gap1", 64'(w), 64'd1);
    sendInstr(0, 256, 4'd11, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1, w);
    checkOutput("stream_ready_gap2", 64'(w), 64'd1);
    checkOutput("stream_words", {expQ[1][31:0], expQ[2][31:0]}, 64'h1022FFFF_08000010);
    verifyRun(0, "stream");

    // Illegal kind followed by ADDI.
    resetDut();
    sendInstr(0, 256, 4'd13, 5'd3, 5'd4, 5'd5, 16'h1234, 26'h0, 1'b0, w);
    @(negedge clk);
    checkOutput("illegal_error_next", {63'd0, errorA}, 64'd1);
    checkOutput("illegal_no_write", 64'(obsA.size()), 64'd0);
    sendInstr(0, 256, 4'd6, 5'd0, 5'd5, 5'd0, 16'h0007, 26'h0, 1'b1, w);
    checkOutput("addi_word", {32'd0, expQ[0][31:0]}, 64'h0000_0000_2005_0007);
    verifyRun(0, "illegal");

    // Ignored fields on SW.
    resetDut();
    sendInstr(0, 256, 4'd8, 5'd29, 5'd31, 5'd31, 16'h0010, 26'h3FFFFFF, 1'b1, w);
    checkOutput("sw_word", {32'd0, expQ[0][31:0]}, 64'h0000_0000_AFBF_0010);
    verifyRun(0, "sw_ignore");

    // Full memory on the 4-word instance: the fifth ADD must never be accepted.
    resetDut();
    for (int i = 0; i < 5; i++)
      sendInstr(1, 4, 4'd0, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                26'($urandom), 1'b0, w);
    verifyRun(1, "full");

    // Reset during the WRITE cycle of the second instruction.
    resetDut();
    sendInstr(0, 256, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, w);
    sendInstr(0, 256, 4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0, w);
    checkOutput("midrst_we_before", {63'd0, ifA.imem_we}, 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_we_after", {63'd0, ifA.imem_we}, 64'd0);
    checkOutput("midrst_count", {55'd0, countA}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    obsA.delete();
    modelClear();
    sendInstr(0, 256, 4'd3, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 1'b1, w);
    verifyRun(0, "midrst");

    // Randomized programs, illegal kinds included.
    for (int r = 0; r < 6; r++) begin
      int n;
      resetDut();
      n = $urandom_range(3, 12);
      for (int i = 0; i < n; i++)
        sendInstr(0, 256, 4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom),
                  5'($urandom), 16'($urandom), 26'($urandom), (i == n - 1), w);
      verifyRun(0, $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
